// File: rtl/sid_voice_mix_pkg.sv
// Shared types and constants for the SID voice mixer.
package sid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        VOL  = 2'd2,
        OUT  = 2'd3
    } mix_state_t;

    localparam logic [11:0] WAVE_OFFSET = 12'h800;
    localparam int          MIX_SHIFT   = 10;
    localparam int          DIGI_SCALE  = 64;
    localparam int          MUL_STEPS   = 8;
    localparam int          VOL_STEPS   = 4;

    // Re-centre the unsigned oscillator output around zero.
    function automatic logic signed [11:0] wave_operand(input logic [11:0] w);
        return signed'(w - WAVE_OFFSET);
    endfunction

endpackage

// File: rtl/sid_voice_mix_if.sv
// Mixer data bus: per-voice inputs, tick, master volume and sample output.
interface sid_voice_mix_if #(
    parameter int VOICES = 3
);
    logic                    clk_en;
    logic [12*VOICES-1:0]    wav;
    logic [8*VOICES-1:0]     env;
    logic                    voice3_off;
    logic [3:0]              mvol;
    logic [15:0]             sample;
    logic                    sample_valid;
    logic                    busy;

    modport master (
        output clk_en, wav, env, voice3_off, mvol,
        input  sample, sample_valid, busy
    );

    modport slave (
        input  clk_en, wav, env, voice3_off, mvol,
        output sample, sample_valid, busy
    );
endinterface

// File: rtl/sid_voice_mix_mul_serial.sv
// Serial signed x unsigned shift-add multiplier, one multiplier bit per step, LSB first.
module sid_mul_serial #(
    parameter int AW = 12,
    parameter int BW = 8,
    parameter int PW = 20
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic                 step,
    input  logic signed [AW-1:0] a,
    input  logic        [BW-1:0] b,
    output logic                 done,
    output logic signed [PW-1:0] result
);

    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    logic        [CW-1:0] cnt_r;
    logic signed [PW-1:0] p_r;
    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] partial_s;

    // Partial product for the current bit; result includes it so the caller can consume it on the last step.
    always_comb begin
        a_ext_s = {{(PW-AW){a[AW-1]}}, a};
        if (b[cnt_r]) begin
            partial_s = a_ext_s <<< cnt_r;
        end else begin
            partial_s = {PW{1'b0}};
        end
        result = p_r + partial_s;
        done   = step && (cnt_r == CW'(BW-1));
    end

    // Partial-sum and bit-index registers; wrap to zero after the last bit so back-to-back products need no start.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cnt_r <= {CW{1'b0}};
            p_r   <= {PW{1'b0}};
        end else if (start) begin
            cnt_r <= {CW{1'b0}};
            p_r   <= {PW{1'b0}};
        end else if (step) begin
            if (done) begin
                cnt_r <= {CW{1'b0}};
                p_r   <= {PW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
                p_r   <= result;
            end
        end
    end

endmodule

// File: rtl/sid_voice_mix.sv
// SID voice mixer: per-voice wave*env products, summed and scaled by master volume, one sample per tick.
// Optional build macro SID_MIX_DIGI_EN adds the master-volume DC step to each sample.
module sid_voice_mix
    import sid_pkg::*;
#(
    parameter int VOICES = 3
) (
    input  logic               clk,
    input  logic               n_reset,
    sid_voice_mix_if.slave     bus
);

    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int MUL_W = 20;
    localparam int ACC_W = 22;
    localparam int M_W   = 26;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MUL  = MUL;
    localparam logic [1:0] S_VOL  = VOL;
    localparam logic [1:0] S_OUT  = OUT;

    logic [1:0]              state_r;
    logic [VW-1:0]           voice_r;
    logic [12*VOICES-1:0]    wav_r;
    logic [8*VOICES-1:0]     env_r;
    logic                    v3off_r;
    logic [3:0]              mvol_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [M_W-1:0]   m_r;
    logic [15:0]             sample_r;
    logic                    valid_r;
    logic                    busy_r;

    logic                    start_s;
    logic                    mul_step_s;
    logic                    vol_step_s;
    logic signed [11:0]      w_s;
    logic [7:0]              e_s;
    logic                    mul_done_s;
    logic signed [MUL_W-1:0] mul_res_s;
    logic                    vol_done_s;
    logic signed [M_W-1:0]   vol_res_s;
    logic [15:0]             sample_s;
    logic                    unused_m_s;

    // Step enables and the operands of the voice currently being multiplied.
    always_comb begin
        start_s    = (state_r == S_IDLE) && bus.clk_en;
        mul_step_s = (state_r == S_MUL);
        vol_step_s = (state_r == S_VOL);
        w_s        = wave_operand(wav_r[int'(voice_r)*12 +: 12]);
        if ((VOICES == 3) && v3off_r && (int'(voice_r) == 2)) begin
            e_s = 8'h00;
        end else begin
            e_s = env_r[int'(voice_r)*8 +: 8];
        end
    end

    sid_mul_serial #(.AW(12), .BW(MUL_STEPS), .PW(MUL_W)) u_mul (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start_s),
        .step    (mul_step_s),
        .a       (w_s),
        .b       (e_s),
        .done    (mul_done_s),
        .result  (mul_res_s)
    );

    sid_mul_serial #(.AW(ACC_W), .BW(VOL_STEPS), .PW(M_W)) u_vol (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start_s),
        .step    (vol_step_s),
        .a       (acc_r),
        .b       (mvol_r),
        .done    (vol_done_s),
        .result  (vol_res_s)
    );

    // Scaled output sample; the slice is an arithmetic shift right truncated to 16 bits.
    always_comb begin
        sample_s = m_r[MIX_SHIFT +: 16];
`ifdef SID_MIX_DIGI_EN
        sample_s = m_r[MIX_SHIFT +: 16] + ({12'h000, mvol_r} * 16'(DIGI_SCALE));
`endif
    end

    assign unused_m_s = ^m_r[MIX_SHIFT-1:0];

    // Mix sequencer: snapshot on tick, accumulate voices, apply volume, publish sample.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r  <= S_IDLE;
            voice_r  <= {VW{1'b0}};
            wav_r    <= {(12*VOICES){1'b0}};
            env_r    <= {(8*VOICES){1'b0}};
            v3off_r  <= 1'b0;
            mvol_r   <= 4'h0;
            acc_r    <= {ACC_W{1'b0}};
            m_r      <= {M_W{1'b0}};
            sample_r <= 16'h0000;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.clk_en) begin
                        wav_r   <= bus.wav;
                        env_r   <= bus.env;
                        v3off_r <= bus.voice3_off;
                        mvol_r  <= bus.mvol;
                        acc_r   <= {ACC_W{1'b0}};
                        voice_r <= {VW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mul_done_s) begin
                        acc_r <= acc_r + {{(ACC_W-MUL_W){mul_res_s[MUL_W-1]}}, mul_res_s};
                        if (int'(voice_r) == VOICES-1) begin
                            state_r <= S_VOL;
                        end else begin
                            voice_r <= voice_r + VW'(1);
                        end
                    end
                end
                S_VOL: begin
                    if (vol_done_s) begin
                        m_r     <= vol_res_s;
                        state_r <= S_OUT;
                    end
                end
                S_OUT: begin
                    sample_r <= sample_s;
                    valid_r  <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample       = sample_r;
    assign bus.sample_valid = valid_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_sid_voice_mix.sv
// Scoreboard bench for sid_voice_mix: directed mixes, busy window, snapshot, reset abort.
module tb_sid_voice_mix;

    typedef struct {
        logic [15:0] val;
        int          edge_n;
    } exp_t;

    logic clk;
    logic n_reset;
    int   edge_no;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    sid_voice_mix_if #(.VOICES(3)) bus ();

    sid_voice_mix #(.VOICES(3)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, edge_no);
        end
    endtask

    function automatic logic [15:0] dc_term(input logic [3:0] mv);
`ifdef SID_MIX_DIGI_EN
        return {12'h000, mv} * 16'd64;
`else
        return 16'h0000 & {12'h000, mv};
`endif
    endfunction

    // Monitor: every sample_valid pulse must match the oldest expected sample and its edge.
    always @(negedge clk) begin
        exp_t x;
        if (bus.sample_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: sample_valid with sample=0x%0h at edge %0d, none expected",
                         bus.sample, edge_no);
            end else begin
                x = sb_q.pop_front();
                check("sample", {16'h0000, bus.sample}, {16'h0000, x.val});
                check("valid_edge", 32'(edge_no), 32'(x.edge_n));
            end
        end
    end

    // One mix from a tick; optional snapshot/busy disturbance and optional reset abort at edge abort_at.
    task automatic run_mix(input logic [35:0] w, input logic [23:0] e, input logic v3,
                           input logic [3:0] mv, input logic [15:0] expv,
                           input bit disturb, input int abort_at);
        int cap;
        @(negedge clk);
        bus.wav        = w;
        bus.env        = e;
        bus.voice3_off = v3;
        bus.mvol       = mv;
        bus.clk_en     = 1'b1;
        @(posedge clk);
        #1;
        cap = edge_no;
        if (abort_at == 0) sb_q.push_back('{expv + dc_term(mv), cap + 29});
        @(negedge clk);
        bus.clk_en = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            if (disturb && k == 5)  bus.wav = 36'h0;
            if (disturb && k == 10) bus.clk_en = 1'b1;
            if (disturb && k == 11) bus.clk_en = 1'b0;
            if (abort_at == k)      n_reset = 1'b0;
            if (abort_at > 0 && k == abort_at + 1) n_reset = 1'b1;
            @(posedge clk);
            #1;
            if (abort_at == 0 || k < abort_at) begin
                check("busy", {31'd0, bus.busy}, {31'd0, (k <= 28)});
            end else if (k == abort_at) begin
                check("abort_sample", {16'h0000, bus.sample}, 32'd0);
                check("abort_valid", {31'd0, bus.sample_valid}, 32'd0);
                check("abort_busy", {31'd0, bus.busy}, 32'd0);
            end else begin
                check("idle_busy", {31'd0, bus.busy}, 32'd0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        n_reset        = 1'b0;
        bus.clk_en     = 1'b1;
        bus.wav        = 36'hFFF_FFF_FFF;
        bus.env        = 24'hFF_FF_FF;
        bus.voice3_off = 1'b0;
        bus.mvol       = 4'hF;

        // Reset held with tick asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_sample", {16'h0000, bus.sample}, 32'd0);
            check("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
            check("rst_busy", {31'd0, bus.busy}, 32'd0);
        end
        @(negedge clk);
        n_reset    = 1'b1;
        bus.clk_en = 1'b0;
        repeat (3) @(negedge clk);

        // Full scale positive and negative
        run_mix(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 1'b0, 4'hF, 16'd22938, 1'b0, 0);
        run_mix(36'h000_000_000, 24'hFF_FF_FF, 1'b0, 4'hF, 16'hA65A, 1'b0, 0);
        // Voice 3 gate
        run_mix(36'hFFF_800_800, 24'hFF_FF_FF, 1'b0, 4'hF, 16'd7646, 1'b0, 0);
        run_mix(36'hFFF_800_800, 24'hFF_FF_FF, 1'b1, 4'hF, 16'd0, 1'b0, 0);
        // Zero master volume
        run_mix(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 1'b0, 4'h0, 16'd0, 1'b0, 0);
        // Mixed levels: voice0 +1*16, voice1 -1*2, voice2 +2047*1 -> 2061*15>>10 = 30
        run_mix(36'hFFF_7FF_801, 24'h01_02_10, 1'b0, 4'hF, 16'd30, 1'b0, 0);
        // Snapshot and busy: inputs change mid-mix, second tick ignored
        run_mix(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 1'b0, 4'hF, 16'd22938, 1'b1, 0);
        // Reset mid-mix aborts; then a silent-voice mix
        run_mix(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 1'b0, 4'hF, 16'd0, 1'b0, 15);
        repeat (5) @(negedge clk);
        run_mix(36'h800_800_800, 24'hFF_FF_FF, 1'b0, 4'h8, 16'd0, 1'b0, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
